// File: rtl/uart_pkg.sv
// Shared UART definitions: default rates, receiver state encoding, accumulator sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int unsigned CLK_HZ_DEF     = 68_000_000;
    localparam int unsigned BAUD_DEF       = 115_200;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    // Phase accumulator width; must hold CLK_HZ (68e6 < 2^29).
    localparam int unsigned ACC_W = 29;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Resize a rate constant to accumulator width plus one carry bit.
    function automatic logic [ACC_W:0] acc_const(input int unsigned v);
        return v[ACC_W:0];
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Fractional rate generator: one-cycle tick at average RATE Hz from a CLK_HZ clock.
// Latency: tick is registered, one cycle after the accumulator wraps.
// Backpressure: none; free-running.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned RATE   = BAUD_DEF * OVERSAMPLE_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick
);

    localparam logic [ACC_W:0] RATE_W = acc_const(RATE);
    localparam logic [ACC_W:0] CLK_W  = acc_const(CLK_HZ);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   wrapped;

    // Add RATE every cycle; once the sum reaches CLK_HZ subtract it and emit a tick.
    always_comb begin
        sum     = {1'b0, acc_q} + RATE_W;
        wrapped = sum - CLK_W;
        acc_d   = sum[ACC_W-1:0];
        tick_d  = 1'b0;
        if (sum >= CLK_W) begin
            acc_d  = wrapped[ACC_W-1:0];
            tick_d = 1'b1;
        end
    end

    // Accumulator and tick registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a one-byte holding register.
// Latency: byte visible one cycle after the mid-stop-bit sample.
// Backpressure: none on the line; a byte arriving while the holding register is unread is dropped and flagged as overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
    parameter int unsigned BAUD       = BAUD_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       uart_rx_i,
    input  logic       uart_rd_i,
    output logic [7:0] uart_dat_o,
    output logic       uart_valid_o,
    output logic       uart_frame_err_o,
    output logic       uart_overrun_o,
    output logic       uart_busy_o
);

    localparam int unsigned CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    // Last tick index of the half start bit and of a full bit period.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

    logic             tick;
    logic [1:0]       sync_q, sync_d;
    logic             rx_s;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             deliver;
    logic             stop_err;

    logic [7:0]       dat_q, dat_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             rd_ack;

    uart_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .RATE   (BAUD * OVERSAMPLE)
    ) u_tick (
        .clk_i  (sys_clk_i),
        .rst_i  (sys_rst_i),
        .tick   (tick)
    );

    // Two-stage synchronizer for the asynchronous line; idles high.
    always_comb begin
        sync_d = {sync_q[0], uart_rx_i};
    end

    assign rx_s = sync_q[1];

    // Frame FSM: start-edge hunt, mid-bit sampling of start/data/stop, break wait.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        deliver  = 1'b0;
        stop_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Restarting the tick count here bounds the phase error to one tick.
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        // A line back high at mid-start is a glitch: silently drop it.
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d          = '0;
                        shift_d[bit_q] = rx_s;
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            stop_err = 1'b1;
                            state_d  = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line so it is not mistaken for a new start bit.
                if (tick && rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register and sticky flags; a read in the delivery cycle makes room for the new byte.
    always_comb begin
        dat_d   = dat_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        rd_ack  = uart_rd_i && valid_q;
        if (uart_rd_i) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (rd_ack) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || rd_ack) begin
                dat_d   = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (stop_err) begin
            ferr_d = 1'b1;
        end
    end

    // All receiver state; reset abandons any frame in flight.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dat_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign uart_dat_o       = dat_q;
    assign uart_valid_o     = valid_q;
    assign uart_frame_err_o = ferr_q;
    assign uart_overrun_o   = ovr_q;
    assign uart_busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames at cycle-accurate bit boundaries, checks against a holding-register model.
// Line rate is raised to 460800 so the run stays short; all timing is in bit and tick fractions, so ratios are unchanged.
// Reads are issued only while the model holds an unread byte.
module tb_uart_rx;

    localparam int unsigned CLK_HZ = 68_000_000;
    localparam int unsigned BAUD   = 460_800;
    localparam real         CPB    = 68000000.0 / 460800.0;         // clock cycles per bit
    localparam real         TICK   = 68000000.0 / (460800.0 * 16.0); // clock cycles per sample tick

    logic       sys_clk_i = 1'b0;
    logic       sys_rst_i = 1'b1;
    logic       uart_rx_i = 1'b1;
    logic       uart_rd_i = 1'b0;
    logic [7:0] uart_dat_o;
    logic       uart_valid_o;
    logic       uart_frame_err_o;
    logic       uart_overrun_o;
    logic       uart_busy_o;

    uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .sys_clk_i        (sys_clk_i),
        .sys_rst_i        (sys_rst_i),
        .uart_rx_i        (uart_rx_i),
        .uart_rd_i        (uart_rd_i),
        .uart_dat_o       (uart_dat_o),
        .uart_valid_o     (uart_valid_o),
        .uart_frame_err_o (uart_frame_err_o),
        .uart_overrun_o   (uart_overrun_o),
        .uart_busy_o      (uart_busy_o)
    );

    always #7 sys_clk_i = ~sys_clk_i;

    int cyc = 0;
    always @(posedge sys_clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the byte holding register and its sticky flags.
    logic [7:0] m_dat   = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk_i);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge sys_clk_i);
    endtask

    task automatic do_reset(input int n);
        sys_rst_i = 1'b1;
        idle(n);
        sys_rst_i = 1'b0;
        m_dat   = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic do_read();
        uart_rd_i = 1'b1;
        @(negedge sys_clk_i);
        uart_rd_i = 1'b0;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // A frame ends either with a good stop bit (byte offered to the holding register) or a bad one.
    task automatic model_rx(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (m_valid) m_ovr = 1'b1;
            else begin
                m_dat   = b;
                m_valid = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_vld"},  32'(uart_valid_o),     32'(m_valid));
        chk({tag, "_dat"},  32'(uart_dat_o),       32'(m_dat));
        chk({tag, "_ferr"}, 32'(uart_frame_err_o), 32'(m_ferr));
        chk({tag, "_ovr"},  32'(uart_overrun_o),   32'(m_ovr));
        chk({tag, "_busy"}, 32'(uart_busy_o),      32'd0);
    endtask

    // Drive the first nbits of {stop, data[7:0] LSB first, start} with bit edges at round-down multiples of cpb.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input real cpb, input int nbits);
        int         t0;
        logic [9:0] fr;
        t0 = cyc;
        fr = {stop_v, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            uart_rx_i = fr[i];
            wait_until(t0 + $rtoi((i + 1) * cpb));
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop_v, input real cpb);
        send_frame(b, stop_v, cpb, 10);
        if (!stop_v) begin
            uart_rx_i = 1'b1;
            idle(20);
        end
        model_rx(b, stop_v);
    endtask

    initial begin
        int         t0;
        int         rise;
        int         lo;
        int         hi;
        real        cpb;
        logic [7:0] b;
        logic       ok;

        idle(3);
        do_reset(5);
        idle(2);
        check_all("reset");

        // 0x55: valid must rise one cycle after the mid-stop sample, ~9.5 bits after the start edge.
        t0   = cyc;
        rise = 0;
        fork
            send_frame(8'h55, 1'b1, CPB, 10);
            begin
                while (uart_valid_o !== 1'b1 && cyc < t0 + 3000) @(negedge sys_clk_i);
                rise = cyc - t0;
            end
        join
        lo = $rtoi(9.5 * CPB - TICK - 6.0);
        hi = $rtoi(9.5 * CPB + TICK + 6.0);
        chk("b55_latency_in_window", 32'(rise >= lo && rise <= hi), 32'd1);
        model_rx(8'h55, 1'b1);
        check_all("b55");
        do_read();
        check_all("b55_rd");

        // Back-to-back 0xA3, 0x0F without a read: second byte dropped, overrun set.
        rx_byte(8'hA3, 1'b1, CPB);
        rx_byte(8'h0F, 1'b1, CPB);
        check_all("ovr");
        do_read();
        check_all("ovr_rd");

        // 0xFF with stop bit low: frame error, nothing delivered, FSM parked until the line rises.
        send_frame(8'hFF, 1'b0, CPB, 10);
        chk("brk_busy", 32'(uart_busy_o), 32'd1);
        model_rx(8'hFF, 1'b0);
        uart_rx_i = 1'b1;
        idle(30);
        check_all("ferr");

        // Low pulse shorter than half a bit on an idle line: rejected without flags.
        do_reset(3);
        idle(5);
        uart_rx_i = 1'b0;
        idle(20);
        chk("glitch_busy", 32'(uart_busy_o), 32'd1);
        idle(30);
        uart_rx_i = 1'b1;
        idle(100);
        check_all("glitch");

        // Reset during data bit 4 with a byte held: everything returns to reset values.
        rx_byte(8'h5A, 1'b1, CPB);
        check_all("pre_rst");
        send_frame(8'hF0, 1'b1, CPB, 5);
        uart_rx_i = 1'b1;
        idle($rtoi(CPB / 2.0));
        do_reset(3);
        idle(1);
        check_all("rst_mid");
        idle($rtoi(2.0 * CPB));
        rx_byte(8'h3C, 1'b1, CPB);
        check_all("b3c");
        do_read();

        // Reset released with the line already low: treated as a fresh start bit.
        send_frame(8'h00, 1'b1, CPB, 3);
        do_reset(3);
        rx_byte(8'hC3, 1'b1, CPB);
        check_all("lowrel");
        do_read();
        idle(40);

        // Sixteen 0x81 frames, half at +2% and half at -2% line rate, read between frames.
        for (int k = 0; k < 16; k++) begin
            cpb = (k < 8) ? CPB / 1.02 : CPB / 0.98;
            rx_byte(8'h81, 1'b1, cpb);
            check_all("b81");
            do_read();
        end
        check_all("b81_end");

        // Random bytes, rates within +/-1%, occasional bad stop bit, random reads and gaps.
        for (int k = 0; k < 8; k++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            cpb = CPB / (1.0 + (real'($urandom_range(0, 20)) - 10.0) / 1000.0);
            idle($urandom_range(1, 40));
            rx_byte(b, ok, cpb);
            idle(2);
            check_all("rnd");
            if (m_valid && $urandom_range(0, 1) == 1) begin
                do_read();
                check_all("rnd_rd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 68000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit.
REQ-004 The block SHALL have port sys_clk_i  input  1  system clock, 68 MHz; sole clock of the block.
REQ-005 The block SHALL have port sys_rst_i  input  1  system reset, synchronous, active-high.
REQ-006 The block SHALL have port uart_rx_i  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 The block SHALL have port uart_rd_i  input  1  one-cycle acknowledge that the held byte has been consumed.
REQ-008 The block SHALL have port uart_dat_o  output  8  received byte, stable while uart_valid_o=1.
REQ-009 The block SHALL have port uart_valid_o  output  1  holding register contains an unread byte.
REQ-010 The block SHALL have port uart_frame_err_o  output  1  sticky: stop bit sampled low.
REQ-011 The block SHALL have port uart_overrun_o  output  1  sticky: a byte was dropped because the holding register was full.
REQ-012 The block SHALL have port uart_busy_o  output  1  high while state is not IDLE.

Function
REQ-013 uart_rx_i SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; all further references are to the synchronized value.
REQ-014 Sample tick SHALL come from a 29-bit phase accumulator: add BAUD*OVERSAMPLE each cycle, subtract CLK_HZ on wrap; tick is a one-cycle pulse at average rate 1843200 Hz (~36.89 cycles apart).
REQ-015 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: on synchronized line = 0, go to START and clear the tick counter.
REQ-017 START: after 8 ticks (mid-bit), line = 0 -> DATA; line = 1 -> IDLE (glitch rejected, no flag).
REQ-018 DATA: every 16 ticks, sample the line into bit index 0..7 (LSB first); after bit 7 -> STOP.
REQ-019 STOP: after 16 ticks, sample; 1 -> deliver byte, go to IDLE; 0 -> set uart_frame_err_o, discard byte, go to BREAK.
REQ-020 BREAK: remain until line = 1 on a tick, then go to IDLE.
REQ-021 Delivery SHALL update uart_dat_o and set uart_valid_o on the cycle after the stop-bit sample cycle (latency 1).
REQ-022 uart_rd_i with uart_valid_o=1 SHALL clear uart_valid_o on the next cycle; uart_rd_i with uart_valid_o=0 SHALL be ignored.
REQ-023 Delivery while uart_valid_o=1 and no uart_rd_i in that cycle SHALL drop the new byte, keep uart_dat_o unchanged, and set uart_overrun_o.
REQ-024 Delivery coincident with uart_rd_i SHALL load the new byte, keep uart_valid_o=1, and not set overrun.
REQ-025 uart_frame_err_o and uart_overrun_o SHALL clear on uart_rd_i (same timing as uart_valid_o) or on reset only.
REQ-026 The accumulator SHALL free-run; tick counter resets on start-edge detection so that sampling phase error is at most one tick.

Reset
REQ-027 Reset SHALL force state IDLE, uart_dat_o=0x00, uart_valid_o=0, uart_frame_err_o=0, uart_overrun_o=0, uart_busy_o=0, synchronizer flops=1, accumulator=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no delivery and no flag; after release, a line held low SHALL be treated as a new start edge.

Structure
REQ-029 CLK_HZ, BAUD, OVERSAMPLE defaults and the state encoding SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-030 The phase accumulator SHALL be a sub-module uart_tick_gen (parameters CLK_HZ, RATE; output tick), reusable by the transmitter.

Verification
REQ-031 Byte 0x55 at 115200 baud, uart_rd_i idle -> uart_valid_o=1, uart_dat_o=0x55 within 1 cycle of mid-stop sample; no flags.
REQ-032 Bytes 0xA3 then 0x0F back-to-back, no read -> uart_dat_o=0xA3, uart_overrun_o=1; read -> valid, overrun cleared.
REQ-033 Frame 0xFF with stop bit held low, then line high -> uart_frame_err_o=1, uart_valid_o=0, state returns IDLE after line high.
REQ-034 200-cycle low glitch on idle line -> return to IDLE, no valid, no flags.
REQ-035 Reset pulse during bit 4 of a frame -> all outputs at reset values; next clean 0x3C received correctly.
REQ-036 Baud offset +/-2% on 0x81 stream of 16 bytes -> all 16 received as 0x81, no flags (with reads between bytes).
